// File: rtl/ntt_bitrev_reorder.sv
// Frame buffer that accepts samples in natural order and
// replays them in bit-reversed index order for NTT stages.
module ntt_bitrev_reorder #(
    parameter int DATA_W  = 8,
    parameter int MAX_LOG = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        log_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy
);

    typedef enum logic {
        S_FILL,
        S_DRAIN
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [DATA_W-1:0]  r_buf [2**MAX_LOG];
    logic [MAX_LOG-1:0] r_wr_cnt;
    logic [MAX_LOG-1:0] r_rd_cnt;
    logic [1:0]         r_n_log;

    logic [1:0]         w_log_eff;
    logic [MAX_LOG-1:0] w_last_in;
    logic [MAX_LOG-1:0] w_last_q;
    logic [MAX_LOG-1:0] w_rev_full;
    logic [MAX_LOG-1:0] w_rev;
    logic [2:0]         w_shift;
    logic               w_in_xfer;
    logic               w_out_xfer;
    logic               w_fill_done;
    logic               w_rd_done;

    // Highest index of a frame of length 1<<l.
    function automatic logic [MAX_LOG-1:0] f_last(input logic [1:0] l);
        logic [MAX_LOG:0] t;
        t = ((MAX_LOG+1)'(1) << l) - (MAX_LOG+1)'(1);
        return t[MAX_LOG-1:0];
    endfunction

    // The first sample of a frame has not latched its length yet.
    assign w_log_eff   = (r_wr_cnt == '0) ? log_n : r_n_log;
    assign w_last_in   = f_last(w_log_eff);
    assign w_last_q    = f_last(r_n_log);
    assign w_in_xfer   = in_valid && (r_state == S_FILL);
    assign w_out_xfer  = out_ready && (r_state == S_DRAIN);
    assign w_fill_done = w_in_xfer && (r_wr_cnt == w_last_in);
    assign w_rd_done   = (r_rd_cnt == w_last_q);
    assign w_shift     = 3'(MAX_LOG) - {1'b0, r_n_log};

    // Reverse all MAX_LOG bits; shifting drops the unused low zeros.
    always_comb begin
        w_rev_full = '0;
        for (int i = 0; i < MAX_LOG; i++) begin
            w_rev_full[i] = r_rd_cnt[MAX_LOG-1-i];
        end
        w_rev = w_rev_full >> w_shift;
    end

    assign out_data = r_buf[w_rev];
    assign busy     = (r_state == S_DRAIN) || (r_wr_cnt != '0);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        unique case (r_state)
            S_FILL: begin
                in_ready = 1'b1;
                if (w_fill_done) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                out_valid = 1'b1;
                out_last  = w_rd_done;
                if (out_ready && w_rd_done) begin
                    w_state_nxt = S_FILL;
                end
            end
            default: w_state_nxt = S_FILL;
        endcase
    end

    // Write/read counters and latched frame length.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
            r_n_log  <= '0;
        end else begin
            if (w_in_xfer) begin
                if (r_wr_cnt == '0) begin
                    r_n_log <= log_n;
                end
                r_wr_cnt <= w_fill_done ? '0 : r_wr_cnt + 1'b1;
            end
            if (w_out_xfer) begin
                r_rd_cnt <= w_rd_done ? '0 : r_rd_cnt + 1'b1;
            end
        end
    end

    // Sample storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_in_xfer) begin
            r_buf[r_wr_cnt] <= in_data;
        end
    end

endmodule

// File: doc/ntt_bitrev_reorder.md
NTT_BITREV_REORDER -- requirements
Module: ntt_bitrev_reorder

Interface
REQ-001 SHALL have parameter DATA_W, default 8: sample width in bits.
REQ-002 SHALL have parameter MAX_LOG, default 3: log2 of the maximum frame length, so at most 8 points.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port log_n, input, 2 bits: log2 of the frame length N = 1<<log_n; legal range 0..MAX_LOG.
REQ-006 SHALL have port in_valid, input, 1 bit: the input sample is valid.
REQ-007 SHALL have port in_data, input, DATA_W bits: input sample, supplied in natural index order.
REQ-008 SHALL have port in_ready, output, 1 bit: the block can accept an input sample.
REQ-009 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-010 SHALL have port out_data, output, DATA_W bits: output sample, delivered in bit-reversed index order.
REQ-011 SHALL have port out_ready, input, 1 bit: the downstream stage accepts out_data.
REQ-012 SHALL have port out_last, output, 1 bit: asserted with the final sample of the frame.
REQ-013 SHALL have port busy, output, 1 bit: asserted while a frame is partially filled or draining.

Function
REQ-014 SHALL hold a register buffer of 2^MAX_LOG entries, each DATA_W bits wide, plus write counter wr_cnt and read counter rd_cnt, each MAX_LOG bits wide.
REQ-015 SHALL implement the states FILL and DRAIN.
REQ-016 SHALL, in FILL, drive in_ready=1 and out_valid=0.
REQ-017 SHALL, in DRAIN, drive in_ready=0 and out_valid=1.
REQ-018 SHALL treat an input transfer as occurring when in_valid & in_ready on a clock edge; on that edge it SHALL write in_data to buf[wr_cnt] and increment wr_cnt.
REQ-019 SHALL latch log_n into n_log_q on the first input transfer of a frame (wr_cnt==0) and ignore log_n at all other times.
REQ-020 SHALL, on the input transfer with wr_cnt==N-1 (N from n_log_q), reset wr_cnt to 0 and go to DRAIN on the next cycle.
REQ-021 SHALL drive out_data = buf[rev(rd_cnt)], where rev reverses the low n_log_q bits of rd_cnt and the upper bits are 0.
REQ-022 SHALL produce out_data combinationally from registered state only, with no combinational path from in_* to out_*.
REQ-023 SHALL treat an output transfer as occurring when out_valid & out_ready; on that edge it SHALL increment rd_cnt.
REQ-024 SHALL drive out_last=1 exactly when in DRAIN and rd_cnt==N-1.
REQ-025 SHALL, on the output transfer with out_last=1, reset rd_cnt to 0 and return to FILL.
REQ-026 SHALL, while out_ready=0, hold out_data, out_valid and out_last stable.
REQ-027 SHALL, for N=1 (log_n=0), accept one sample, then drain it with out_last=1 on the first output cycle.
REQ-028 SHALL drive busy=1 when state==DRAIN or wr_cnt!=0.
REQ-029 SHALL have a minimum frame turnaround of N fill cycles plus N drain cycles, with no overlap between fill and drain.
REQ-030 SHALL treat log_n > MAX_LOG as illegal, with undefined behaviour; verification SHALL flag it with an assertion.

Reset
REQ-031 SHALL, when rst=1 at a clock edge, set state=FILL, wr_cnt=0, rd_cnt=0 and n_log_q=0 on that edge, overriding any simultaneous transfer.
REQ-032 SHALL, after reset, present in_ready=1, out_valid=0, out_last=0 and busy=0.
REQ-033 SHALL leave buffer contents unreset; out_data is don't-care while out_valid=0.
REQ-034 SHALL, on a reset asserted mid-fill or mid-drain, discard the partial frame and emit no further output from it.

Verification
REQ-035 Bench SHALL cover: log_n=3, inputs 0..7 back-to-back, out_ready=1 -> outputs 0,4,2,6,1,5,3,7; out_last only on 7; in_ready=0 for those 8 cycles.
REQ-036 Bench SHALL cover: log_n=2, inputs 10,11,12,13 -> outputs 10,12,11,13; then log_n=1, inputs 20,21 -> outputs 20,21.
REQ-037 Bench SHALL cover: log_n=0, input 0x5A -> one output 0x5A with out_last=1; state back to FILL next cycle.
REQ-038 Bench SHALL cover: log_n=3 drain with out_ready toggled randomly -> same order as REQ-035; out_data stable while stalled; in_ready stays 0.
REQ-039 Bench SHALL cover: log_n changed to 1 after the first sample of a log_n=3 frame -> frame still completes as 8 points.
REQ-040 Bench SHALL cover: rst pulsed after 5 samples -> busy=0 and in_ready=1 next cycle; a following log_n=2 frame 1,2,3,4 -> outputs 1,3,2,4.
